// File: rtl/mem_port_arbiter.sv
// Two-master arbiter sharing one single-port memory between instruction fetch and data.
// Data has fixed priority with a starvation limit. Optional stall counter: ARB_PERF_CNT_EN.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   instr_address,
    input  logic                instr_read,
    output logic [DATA_W-1:0]   instr_readdata,
    output logic                instr_waitrequest,
    input  logic [ADDR_W-1:0]   data_address,
    input  logic                data_read,
    input  logic                data_write,
    input  logic [DATA_W/8-1:0] data_byteenable,
    input  logic [DATA_W-1:0]   data_writedata,
    output logic [DATA_W-1:0]   data_readdata,
    output logic                data_waitrequest,
    output logic [ADDR_W-1:0]   mem_address,
    output logic                mem_read,
    output logic                mem_write,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic [DATA_W-1:0]   mem_writedata,
    input  logic [DATA_W-1:0]   mem_readdata,
    input  logic                mem_waitrequest,
    output logic [31:0]         stall_cycles
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GNT_I = 2'd1;
    localparam logic [1:0] GNT_D = 2'd2;
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [1:0]        state;
    logic [3:0]        starve_cnt;
    logic              instr_at_gnt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] instr_rd_q;
    logic [DATA_W-1:0] data_rd_q;

    logic data_req, i_strb, d_rd, d_wr, i_done, d_done;

    always_comb begin
        data_req = data_read | data_write;
        i_strb   = (state == GNT_I) && instr_read;
        // a simultaneous read and write is served as a write
        d_wr     = (state == GNT_D) && data_write;
        d_rd     = (state == GNT_D) && data_read && !data_write;
        i_done   = i_strb && !mem_waitrequest;
        d_done   = (d_wr || d_rd) && !mem_waitrequest;

        mem_read  = i_strb | d_rd;
        mem_write = d_wr;

        case (state)
            GNT_I:   mem_address = instr_address;
            GNT_D:   mem_address = data_address;
            default: mem_address = addr_q;
        endcase
        mem_writedata = (state == GNT_D) ? data_writedata : wdata_q;

        if (i_strb)             mem_byteenable = '1;
        else if (d_wr || d_rd)  mem_byteenable = data_byteenable;
        else                    mem_byteenable = '0;

        instr_waitrequest = instr_read && !i_done;
        data_waitrequest  = data_req && !d_done;
        instr_readdata    = i_done ? mem_readdata : instr_rd_q;
        data_readdata     = (d_done && d_rd) ? mem_readdata : data_rd_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            starve_cnt   <= '0;
            instr_at_gnt <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            instr_rd_q   <= '0;
            data_rd_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (data_req && !(instr_read && starve_cnt == LIMIT)) begin
                        state        <= GNT_D;
                        instr_at_gnt <= instr_read;
                    end else if (instr_read) begin
                        state <= GNT_I;
                    end
                end
                GNT_I: if (!instr_read || i_done) state <= IDLE;
                GNT_D: if (!data_req || d_done)   state <= IDLE;
                default: state <= IDLE;
            endcase

            if ((state == IDLE && !instr_read) || i_done)
                starve_cnt <= '0;
            else if (d_done && instr_at_gnt && starve_cnt != LIMIT)
                starve_cnt <= starve_cnt + 4'd1;

            if (state != IDLE) addr_q <= mem_address;
            if (state == GNT_D) wdata_q <= data_writedata;
            if (i_done) instr_rd_q <= mem_readdata;
            if (d_done && d_rd) data_rd_q <= mem_readdata;
        end
    end

`ifdef ARB_PERF_CNT_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stall_q <= '0;
        else if ((instr_read && instr_waitrequest) || (data_req && data_waitrequest))
            stall_q <= stall_q + 32'd1;
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = 32'd0;
`endif

endmodule
